// File: rtl/tmr_cfg_pkg.sv
// tmr_cfg_pkg: shared response codes, FSM state types and address helpers for tmr_cfg_regs.
package tmr_cfg_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic out_of_range(input logic [63:0] addr, input int n);
    return addr >= (64'(n) << 2);
  endfunction
endpackage

// File: rtl/tmr_cfg_wr_fsm.sv
// tmr_cfg_wr_fsm: AXI4-Lite AW/W capture in either order plus B response; emits a write strobe on the completing edge.
module tmr_cfg_wr_fsm import tmr_cfg_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DW = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int IW = idx_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DW-1:0]     wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              wr_en,
  output logic [IW-1:0]     wr_idx,
  output logic [DW-1:0]     wr_data
);
  wr_state_t state;
  logic [ADDR_W-1:0] addr_q, addr_e;
  logic [DW-1:0] data_q;
  logic aw_hs, w_hs, complete, bad;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign addr_e = aw_hs ? awaddr : addr_q;
  assign wr_data = w_hs ? wdata : data_q;
  assign wr_idx = addr_e[2 +: IW];
  assign complete = (aw_hs && w_hs) || (state == W_HAVE_A && w_hs) || (state == W_HAVE_D && aw_hs);
  assign bad = out_of_range(64'(addr_e), NUM_REGS) || RO_MASK[wr_idx];
  assign wr_en = complete && !bad;
  // readies are registered from the next state, so they come up one cycle after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= W_IDLE;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs) data_q <= wdata;
      if (complete) begin
        state <= W_RESP;
        bvalid <= 1'b1;
        bresp <= bad ? RESP_SLVERR : RESP_OKAY;
        awready <= 1'b0;
        wready <= 1'b0;
      end else if (state == W_RESP) begin
        if (bready) begin
          state <= W_IDLE;
          bvalid <= 1'b0;
          awready <= 1'b1;
          wready <= 1'b1;
        end
      end else if (aw_hs) begin
        state <= W_HAVE_A;
        awready <= 1'b0;
        wready <= 1'b1;
      end else if (w_hs) begin
        state <= W_HAVE_D;
        awready <= 1'b1;
        wready <= 1'b0;
      end else begin
        awready <= state != W_HAVE_A;
        wready <= state != W_HAVE_D;
      end
    end
endmodule

// File: rtl/tmr_cfg_regs.sv
// tmr_cfg_regs: AXI4-Lite config register bank for one TMR replica; timing depends only on bus inputs.
// Optional TMR_CFG_PARITY_EN adds per-register even parity and a parity_err read pulse.
module tmr_cfg_regs import tmr_cfg_pkg::*; #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                             axi_aclk,
  input  logic                             axi_resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    s00_axi_awaddr,
  input  logic                             s00_axi_awvalid,
  output logic                             s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]    s00_axi_wdata,
  input  logic                             s00_axi_wvalid,
  output logic                             s00_axi_wready,
  output logic [1:0]                       s00_axi_bresp,
  output logic                             s00_axi_bvalid,
  input  logic                             s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    s00_axi_araddr,
  input  logic                             s00_axi_arvalid,
  output logic                             s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]    s00_axi_rdata,
  output logic [1:0]                       s00_axi_rresp,
  output logic                             s00_axi_rvalid,
  input  logic                             s00_axi_rready,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_out,
`ifdef TMR_CFG_PARITY_EN
  output logic                             parity_err,
`endif
  output logic [NUM_REGS-1:0]              cfg_wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = idx_w(NUM_REGS);
  logic [1:0] rst_sync;
  logic rst_n;
  logic wr_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_val;
  logic [DW-1:0] regs [NUM_REGS];
  logic rd_oor, rd_ro, rd_par_bad, ar_hs;
  rd_state_t rstate;
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  tmr_cfg_wr_fsm #(
    .ADDR_W(C_S_AXI_ADDR_WIDTH), .DW(DW), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_wr (
    .clk(axi_aclk), .rst_n(rst_n),
    .awaddr(s00_axi_awaddr), .awvalid(s00_axi_awvalid), .awready(s00_axi_awready),
    .wdata(s00_axi_wdata), .wvalid(s00_axi_wvalid), .wready(s00_axi_wready),
    .bresp(s00_axi_bresp), .bvalid(s00_axi_bvalid), .bready(s00_axi_bready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );
  always_ff @(posedge axi_aclk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      cfg_wr_pulse <= '0;
    end else begin
      if (wr_en) regs[wr_idx] <= wr_data;
      cfg_wr_pulse <= wr_en ? NUM_REGS'(1) << wr_idx : '0;
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign cfg_out[i*DW +: DW] = RO_MASK[i] ? '0 : regs[i];
  end
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign rd_idx = s00_axi_araddr[2 +: IW];
  assign rd_oor = out_of_range(64'(s00_axi_araddr), NUM_REGS);
  assign rd_ro = RO_MASK[rd_idx];
  assign rd_val = rd_oor ? '0 : rd_ro ? status_in[rd_idx*DW +: DW] : regs[rd_idx];
`ifdef TMR_CFG_PARITY_EN
  logic [NUM_REGS-1:0] par;
  assign rd_par_bad = !rd_oor && !rd_ro && ((^regs[rd_idx]) != par[rd_idx]);
  always_ff @(posedge axi_aclk or negedge rst_n)
    if (!rst_n) begin
      par <= '0;
      parity_err <= 1'b0;
    end else begin
      if (wr_en) par[wr_idx] <= ^wr_data;
      parity_err <= ar_hs && rd_par_bad;
    end
`else
  assign rd_par_bad = 1'b0;
`endif
  // regs are sampled before this edge's write lands, so a same-edge read sees the old value
  always_ff @(posedge axi_aclk or negedge rst_n)
    if (!rst_n) begin
      rstate <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= RESP_OKAY;
    end else if (rstate == R_RESP) begin
      if (s00_axi_rready) begin
        rstate <= R_IDLE;
        s00_axi_rvalid <= 1'b0;
        s00_axi_arready <= 1'b1;
      end
    end else if (ar_hs) begin
      rstate <= R_RESP;
      s00_axi_rvalid <= 1'b1;
      s00_axi_arready <= 1'b0;
      s00_axi_rdata <= rd_val;
      s00_axi_rresp <= (rd_oor || rd_par_bad) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      s00_axi_arready <= 1'b1;
    end
endmodule

// File: tb/tb_tmr_cfg_regs.sv
// tb_tmr_cfg_regs: directed and randomized AXI4-Lite checks of tmr_cfg_regs against an array model.
module tb_tmr_cfg_regs;
  localparam int N = 8;
  localparam logic [N-1:0] ROM = 8'h80;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic axi_resetn = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [N*32-1:0] status_in, cfg_out;
  logic [N-1:0] cfg_wr_pulse;
  logic [31:0] model [N];
  logic [31:0] stat [N];
  int errors = 0, checks = 0, pulse_cnt = 0;

  always_comb for (int k = 0; k < N; k++) status_in[k*32 +: 32] = stat[k];
  always @(negedge clk) pulse_cnt <= pulse_cnt + $countones(cfg_wr_pulse);

  tmr_cfg_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .NUM_REGS(N), .RO_MASK(ROM)) dut (
    .axi_aclk(clk), .axi_resetn(axi_resetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .status_in(status_in), .cfg_out(cfg_out), .cfg_wr_pulse(cfg_wr_pulse)
  );

  function automatic logic [N*32-1:0] model_vec();
    logic [N*32-1:0] v;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = (k == 7) ? 32'h0 : model[k];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int ad, input int wd,
                           output logic [1:0] resp, output bit ok);
    bit a_done, w_done, ah, wh;
    a_done = 0; w_done = 0; ok = 0; resp = 2'bxx;
    awaddr = a; wdata = d;
    for (int c = 0; c < 100 && !(a_done && w_done); c++) begin
      if (!a_done && c >= ad) awvalid = 1;
      if (!w_done && c >= wd) wvalid = 1;
      @(negedge clk);
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) begin a_done = 1; awvalid = 0; end
      if (wh) begin w_done = 1; wvalid = 0; end
    end
    awvalid = 0; wvalid = 0;
    bready = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; ok = a_done && w_done; break; end
    end
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
    bit go;
    go = 0; ok = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1;
    for (int c = 0; c < 100 && !go; c++) begin
      @(negedge clk);
      go = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    rready = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; resp = rresp; ok = go; break; end
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    #2 axi_resetn = 0;
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, cfg_wr_pulse} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b required 0", {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, cfg_wr_pulse});
    end
    checks++;
    if (cfg_out !== '0) begin errors++; $display("FAIL reset_cfg: got %h required 0", cfg_out); end
    repeat (3) @(posedge clk);
    #1 axi_resetn = 1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      errors++; $display("FAIL reset_release_ready: got %b required 11100", {awready, wready, arready, bvalid, rvalid});
    end
  endtask

  task automatic test_aw_w_together();
    awaddr = 32'h4; wdata = 32'hDEADBEEF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL together_early_bvalid: got %b required 0", bvalid); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL together_bresp: got %b required 100", {bvalid, bresp}); end
    checks++;
    if (cfg_out[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL together_cfg1: got %h required deadbeef", cfg_out[63:32]); end
    checks++;
    if (cfg_wr_pulse !== 8'h02) begin errors++; $display("FAIL together_pulse: got %h required 02", cfg_wr_pulse); end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    checks++;
    if ({cfg_wr_pulse, bvalid} !== 9'h0) begin errors++; $display("FAIL together_after: got %h required 0", {cfg_wr_pulse, bvalid}); end
    model[1] = 32'hDEADBEEF;
    @(posedge clk); #1;
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; bit ok;
    wdata = 32'h12345678; wvalid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    wvalid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({wready, awready, bvalid} !== 3'b010) begin errors++; $display("FAIL wfirst_hold%0d: got %b required 010", c, {wready, awready, bvalid}); end
      @(posedge clk); #1;
    end
    awaddr = 32'h8; awvalid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 0;
    @(negedge clk);
    checks++;
    if ({bvalid, bresp, cfg_out[95:64]} !== {3'b100, 32'h12345678}) begin
      errors++; $display("FAIL wfirst_land: got %b/%h required 100/12345678", {bvalid, bresp}, cfg_out[95:64]);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    model[2] = 32'h12345678;
    axi_read(32'h8, d, r, ok);
    checks++;
    if (!ok || d !== 32'h12345678 || r !== 2'b00) begin errors++; $display("FAIL wfirst_read: got %h/%b ok=%0d required 12345678/00", d, r, ok); end
  endtask

  task automatic test_out_of_range_and_ro();
    logic [31:0] d; logic [1:0] r; bit ok; int pc;
    pc = pulse_cnt;
    axi_write(32'h20, 32'hCAFEF00D, 0, 0, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin errors++; $display("FAIL oor_write: got %b ok=%0d required 10", r, ok); end
    checks++;
    if (cfg_out !== model_vec() || pulse_cnt !== pc) begin errors++; $display("FAIL oor_nochange: got %h pulses=%0d required %h pulses=%0d", cfg_out, pulse_cnt, model_vec(), pc); end
    axi_read(32'h20, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read: got %h/%b required 0/10", d, r); end
    stat[7] = 32'hA5A5A5A5;
    axi_read(32'h1C, d, r, ok);
    checks++;
    if (!ok || d !== 32'hA5A5A5A5 || r !== 2'b00) begin errors++; $display("FAIL ro_read: got %h/%b required a5a5a5a5/00", d, r); end
    axi_write(32'h1C, 32'h11112222, 0, 2, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin errors++; $display("FAIL ro_write: got %b required 10", r); end
    checks++;
    if (cfg_out !== model_vec() || pulse_cnt !== pc) begin errors++; $display("FAIL ro_nochange: got %h pulses=%0d required %h pulses=%0d", cfg_out, pulse_cnt, model_vec(), pc); end
  endtask

  task automatic test_backpressure();
    awaddr = 32'h1C; wdata = 32'h5; awvalid = 1; wvalid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b11000) begin errors++; $display("FAIL bp_hold%0d: got %b required 11000", c, {bvalid, bresp, awready, wready}); end
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic test_same_edge();
    logic [1:0] r; bit ok;
    axi_write(32'h8, 32'h1, 0, 0, r, ok);
    model[2] = 32'h1;
    awaddr = 32'h8; wdata = 32'h2; araddr = 32'h8;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL same_ready: got %b required 111", {awready, wready, arready}); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    checks++;
    if ({rvalid, rdata, bvalid, cfg_out[95:64]} !== {1'b1, 32'h1, 1'b1, 32'h2}) begin
      errors++; $display("FAIL same_edge: got rdata=%h cfg2=%h v=%b%b required 1/2/11", rdata, cfg_out[95:64], rvalid, bvalid);
    end
    rready = 1; bready = 1;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    model[2] = 32'h2;
  endtask

  task automatic test_back_to_back();
    int bcnt, rcnt, bad, pc;
    bcnt = 0; rcnt = 0; bad = 0; pc = pulse_cnt;
    awaddr = 32'hC; wdata = $urandom; awvalid = 1; wvalid = 1; bready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bvalid) bcnt++;
    end
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    bready = 0;
    model[3] = wdata;
    checks++;
    if (bcnt !== 10 || pulse_cnt - pc !== 10) begin errors++; $display("FAIL b2b_write: got %0d resp %0d pulses required 10/10", bcnt, pulse_cnt - pc); end
    araddr = 32'hC; arvalid = 1; rready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rvalid) begin rcnt++; if (rdata !== model[3]) bad++; end
    end
    arvalid = 0;
    @(posedge clk); #1;
    rready = 0;
    checks++;
    if (rcnt !== 10 || bad !== 0) begin errors++; $display("FAIL b2b_read: got %0d reads %0d bad required 10/0", rcnt, bad); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd; logic [1:0] r, er; bit ok; int idx; bit oor;
    for (int it = 0; it < 60; it++) begin
      a = $urandom_range(0, 39);
      d = $urandom;
      idx = a / 4;
      oor = a >= N * 4;
      if ($urandom_range(0, 3) == 0) stat[7] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), r, ok);
        er = (oor || idx == 7) ? 2'b10 : 2'b00;
        if (er == 2'b00) model[idx] = d;
        checks++;
        if (!ok || r !== er || cfg_out !== model_vec()) begin
          errors++; $display("FAIL rnd_write%0d a=%h: got %b cfg=%h required %b cfg=%h", it, a, r, cfg_out, er, model_vec());
        end
      end else begin
        axi_read(a, rd, r, ok);
        er = oor ? 2'b10 : 2'b00;
        d = oor ? 32'h0 : (idx == 7) ? stat[7] : model[idx];
        checks++;
        if (!ok || r !== er || rd !== d) begin errors++; $display("FAIL rnd_read%0d a=%h: got %h/%b required %h/%b", it, a, rd, r, d, er); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit ok; int bad;
    bad = 0;
    model[5] = 32'h77;
    axi_write(32'h14, 32'h77, 0, 0, r, ok);
    awaddr = 32'h10; awvalid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 0;
    @(negedge clk);
    checks++;
    if ({awready, wready} !== 2'b01) begin errors++; $display("FAIL mid_have_a: got %b required 01", {awready, wready}); end
    #2 axi_resetn = 0;
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, cfg_wr_pulse, cfg_out} !== '0) begin
      errors++; $display("FAIL mid_reset_zero: got cfg=%h rdata=%h ctl=%b", cfg_out, rdata, {awready, wready, bvalid, arready, rvalid, bresp, rresp});
    end
    for (int k = 0; k < N; k++) model[k] = 32'h0;
    @(posedge clk); #1;
    axi_resetn = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bvalid !== 1'b0 || cfg_wr_pulse !== '0) bad++;
    end
    @(posedge clk); #1;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mid_no_bvalid: got %0d bad cycles required 0", bad); end
    axi_read(32'h14, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL mid_read_cleared: got %h/%b required 0/00", d, r); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin model[k] = 32'h0; stat[k] = 32'h0; end
    stat[3] = 32'h33333333;
    test_reset();
    test_aw_w_together();
    test_w_before_aw();
    test_out_of_range_and_ro();
    test_backpressure();
    test_same_edge();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
